// File: rtl/rpm_controller.sv
// Control FSM for a Russian-peasant (shift-and-add) multiplier datapath.
// Sequences the A/B/P register loads and mux select; holds no arithmetic of its own.
module rpm_controller #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             b_lsb,
    input  logic             b_zero,
    output logic             a_ld,
    output logic             b_ld,
    output logic             p_ld,
    output logic             src_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_cnt,
    output logic [2:0]       state_dbg
);

    // Handshake: start is a request sampled only in IDLE (ignored elsewhere, never queued);
    // busy is high from INIT through the final CHECK; done pulses for one cycle when P is final.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_ACC   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            iter_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) begin
                iter_cnt <= '0;
            end else if (state_q == S_SHIFT && iter_cnt != CNT_MAX) begin
                iter_cnt <= iter_cnt + 1'b1;
            end
        end
    end

    // Next-state and Moore output decode; the WIDTH cap backs up b_zero as a safety stop.
    always_comb begin
        state_d = S_IDLE;
        a_ld    = 1'b0;
        b_ld    = 1'b0;
        p_ld    = 1'b0;
        src_sel = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = start ? S_INIT : S_IDLE;
            end
            S_INIT: begin
                a_ld    = 1'b1;
                b_ld    = 1'b1;
                p_ld    = 1'b1;
                busy    = 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (b_zero || iter_cnt == CNT_MAX) begin
                    state_d = S_DONE;
                end else if (b_lsb) begin
                    state_d = S_ACC;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ACC: begin
                p_ld    = 1'b1;
                src_sel = 1'b1;
                busy    = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                a_ld    = 1'b1;
                b_ld    = 1'b1;
                src_sel = 1'b1;
                busy    = 1'b1;
                state_d = S_CHECK;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_rpm_controller.sv
// Bench for rpm_controller: a behavioural A/B/P datapath closes the loop and each
// operation is checked against plain arithmetic (product, MSB index, popcount).
`timescale 1ns/1ps
module tb_rpm_controller;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    // Observed-state codes, derived from the output pattern only.
    localparam int C_IDLE = 0, C_INIT = 1, C_CHECK = 2, C_ACC = 3, C_SHIFT = 4, C_DONE = 5, C_BAD = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             b_lsb;
    logic             b_zero;
    logic             a_ld, b_ld, p_ld, src_sel, busy, done;
    logic [CNT_W-1:0] iter_cnt;
    logic [2:0]       state_dbg;

    int checks = 0;
    int errors = 0;

    // Behavioural datapath plus an override used to pin b_zero low.
    logic [31:0] opa, opb;
    logic [31:0] dp_a, dp_b, dp_p;
    logic        force_bz;
    logic        lsb_f;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    always #5 clk = ~clk;

    rpm_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .b_lsb(b_lsb), .b_zero(b_zero),
        .a_ld(a_ld), .b_ld(b_ld), .p_ld(p_ld), .src_sel(src_sel),
        .busy(busy), .done(done), .iter_cnt(iter_cnt), .state_dbg(state_dbg)
    );

    always @(posedge clk) begin
        if (a_ld) dp_a <= src_sel ? (dp_a << 1) : opa;
        if (b_ld) dp_b <= src_sel ? (dp_b >> 1) : opb;
        if (p_ld) dp_p <= src_sel ? (dp_p + dp_a) : 32'd0;
    end

    assign b_lsb  = force_bz ? lsb_f : dp_b[0];
    assign b_zero = force_bz ? 1'b0 : (dp_b == 32'd0);

    function automatic int decode();
        casez ({a_ld, b_ld, p_ld, src_sel, busy, done})
            6'b000000: return C_IDLE;
            6'b111010: return C_INIT;
            6'b000?10: return C_CHECK;
            6'b001110: return C_ACC;
            6'b110110: return C_SHIFT;
            6'b000?01: return C_DONE;
            default:   return C_BAD;
        endcase
    endfunction

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; start = 1'b1; force_bz = 1'b0; lsb_f = 1'b0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_ld, b_ld, p_ld, src_sel, busy, done} !== 6'b0 || iter_cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got outs=%b iter=%0d, want outs=000000 iter=0",
                     {a_ld, b_ld, p_ld, src_sel, busy, done}, iter_cnt);
        end
        rst = 1'b0; start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (decode() != C_IDLE) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle_hold: got %0d non-IDLE cycles without start, want 0", bad);
        end
    endtask

    // Runs one multiplication and compares sequence, latency, handshake and result to the model.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hold_start,
                         output int done_cyc);
        int k = 0, p = 0, n, code, pld_cnt = 0, busy_bad = 0, seq_bad = 0;
        bit got_done = 0;
        logic [31:0] prod;
        logic [CNT_W-1:0] it_done = '0;
        logic [31:0] p_done = '0;
        prod = a * b;
        for (int i = 0; i < 32; i++) if (b[i]) begin k = i + 1; p++; end
        exp_q.delete(); obs_q.delete();
        exp_q.push_back(C_INIT);
        for (int i = 0; i < k; i++) begin
            exp_q.push_back(C_CHECK);
            if (b[i]) exp_q.push_back(C_ACC);
            exp_q.push_back(C_SHIFT);
        end
        exp_q.push_back(C_CHECK);
        exp_q.push_back(C_DONE);

        opa = a; opb = b; done_cyc = -1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (n = 1; n <= 200; n++) begin
            code = decode();
            obs_q.push_back(code);
            if (p_ld && src_sel) pld_cnt++;
            if ((code == C_DONE) ? busy : !busy) busy_bad++;
            start = hold_start && (code == C_CHECK || code == C_DONE);
            if (code == C_DONE) begin
                got_done = 1; done_cyc = n; it_done = iter_cnt; p_done = dp_p;
                break;
            end
            if (code == C_IDLE || code == C_BAD) break;
            @(negedge clk);
        end

        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL op_done_seen: a=%h b=%h no done within bound, want done at cycle %0d",
                     a, b, 3 + 2 * k + p);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) seq_bad = 1;
        else foreach (exp_q[i]) if (obs_q[i] != exp_q[i]) seq_bad = 1;
        if (seq_bad) begin
            errors++;
            $display("FAIL op_sequence: a=%h b=%h got %0d states, want %0d", a, b,
                     obs_q.size(), exp_q.size());
        end
        checks++;
        if (done_cyc != 3 + 2 * k + p) begin
            errors++;
            $display("FAIL op_latency: b=%h got done cycle %0d, want %0d", b, done_cyc, 3 + 2 * k + p);
        end
        checks++;
        if (it_done !== CNT_W'(k) || p_done !== prod || pld_cnt != p || busy_bad != 0) begin
            errors++;
            $display("FAIL op_result: a=%h b=%h got iter=%0d P=%h acc=%0d busy_bad=%0d, want iter=%0d P=%h acc=%0d busy_bad=0",
                     a, b, it_done, p_done, pld_cnt, busy_bad, k, prod, p);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (decode() != C_IDLE || iter_cnt !== CNT_W'(k)) begin
            errors++;
            $display("FAIL op_post_idle: got code=%0d iter=%0d, want code=%0d iter=%0d",
                     decode(), iter_cnt, C_IDLE, k);
        end
    endtask

    task automatic test_zero();
        int dc;
        do_op(32'd7, 32'd0, 1'b0, dc);
        checks++;
        if (dc != 3 || dp_p !== 32'd0) begin
            errors++;
            $display("FAIL zero_operand: got done=%0d P=%h, want done=3 P=0", dc, dp_p);
        end
    endtask

    task automatic test_6x5();
        int dc;
        do_op(32'd6, 32'd5, 1'b0, dc);
        checks++;
        if (dc != 11 || dp_p !== 32'd30) begin
            errors++;
            $display("FAIL six_by_five: got done=%0d P=%0d, want done=11 P=30", dc, dp_p);
        end
    endtask

    task automatic test_max();
        int dc;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, dc);
        checks++;
        if (dc != 99 || dp_p !== 32'h0000_0001) begin
            errors++;
            $display("FAIL max_operands: got done=%0d P=%h, want done=99 P=00000001", dc, dp_p);
        end
    endtask

    task automatic test_random();
        int dc;
        logic [31:0] a, b;
        for (int t = 0; t < 16; t++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            do_op(a, b, bit'($urandom_range(0, 1)), dc);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        do_op(32'd3, 32'd9, 1'b1, dc);
        do_op(32'd11, 32'd2, 1'b0, dc);
        do_op(32'h1234, 32'h80, 1'b1, dc);
    endtask

    task automatic test_cap();
        int shifts = 0, code, max_it = 0;
        bit got_done = 0;
        logic [CNT_W-1:0] it_done = '0;
        force_bz = 1'b1;
        opa = 32'd1; opb = 32'd1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            code = decode();
            if (int'(iter_cnt) > max_it) max_it = int'(iter_cnt);
            if (code == C_SHIFT) shifts++;
            if (code == C_DONE) begin got_done = 1; it_done = iter_cnt; break; end
            if (code == C_IDLE || code == C_BAD) break;
            lsb_f = 1'($urandom);
            @(negedge clk);
        end
        checks++;
        if (!got_done || it_done !== CNT_W'(WIDTH) || shifts != WIDTH) begin
            errors++;
            $display("FAIL cap_stop: got done=%0d iter=%0d shifts=%0d, want done=1 iter=%0d shifts=%0d",
                     got_done, it_done, shifts, WIDTH, WIDTH);
        end
        checks++;
        if (max_it > WIDTH) begin
            errors++;
            $display("FAIL cap_bound: got max iter=%0d, want <= %0d", max_it, WIDTH);
        end
        @(negedge clk);
        force_bz = 1'b0;
    endtask

    task automatic test_abort();
        int dones = 0, non_idle = 0;
        bit hit = 0;
        opa = 32'd3; opb = 32'b1011;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            if (decode() == C_ACC && iter_cnt != '0) begin hit = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach_acc: got no ACC with iter>0 within bound, want one");
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (decode() != C_IDLE || iter_cnt !== '0) begin
            errors++;
            $display("FAIL abort_idle: got code=%0d iter=%0d, want code=%0d iter=0",
                     decode(), iter_cnt, C_IDLE);
        end
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
            if (decode() != C_IDLE) non_idle++;
        end
        checks++;
        if (dones != 0 || non_idle != 0) begin
            errors++;
            $display("FAIL abort_quiet: got dones=%0d non_idle=%0d, want 0 and 0", dones, non_idle);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_6x5();
        test_max();
        test_random();
        test_back_to_back();
        test_cap();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
